echo_meas_sequencer: RTL and testbench
======================================

// Module: echo_meas_sequencer
// PURPOSE
// - Top-level scheduler for one 90 kHz ultrasound ranging cycle, repeated every PERIOD_CYC clocks.
// - Per cycle: flush the sample FIFO, issue the correlator start pulse and drive the TX burst.
// - Gates ADC-to-FIFO capture, waits for the correlator's done level (or a timeout), then latches hit/tof/peak into stable result registers.
// - Sits between the ADC capture writer, the transducer driver and the echo correlation datapath.
// PARAMETERS
// PERIOD_CYC        500000  clocks START-to-START (10 ms at 50 MHz)
// TX_HALF_CYC       278     clocks per TX half-period (~90 kHz)
// TX_CYCLES         10      TX periods per burst; must be >=1
// FIFO_CLR_CYC      8       clocks fifo_aclr is held high before each START
// PROC_TIMEOUT_CYC  400000  period_cnt value that aborts the wait; must be < PERIOD_CYC-FIFO_CLR_CYC-2
// PORTS
// clk_50M          in   1   system clock, 50 MHz
// rst_n            in   1   asynchronous, active-low reset
// enable           in   1   run continuous measurements while high
// proc_done        in   1   correlator processing-complete level
// hit_flag         in   1   correlator echo-found flag
// echo_tof         in   20  correlator echo sample index
// echo_peak        in   18  correlator peak magnitude
// sys_start_pulse  out  1   one-cycle start strobe to the correlator
// fifo_aclr        out  1   FIFO asynchronous clear
// fifo_wren_en     out  1   capture-writer enable; FIFO writes are allowed only while high
// tx_out           out  1   transducer drive square wave
// result_valid     out  1   one-cycle strobe when result_* update
// result_hit       out  1   latched hit; forced 0 on timeout
// result_tof       out  20  latched echo_tof
// result_peak      out  18  latched echo_peak
// timeout_err      out  1   one-cycle strobe, coincident with result_valid, on timeout
// busy             out  1   high in every state except IDLE and WAIT
// meas_cnt         out  16  completed measurements, wraps at 16'hFFFF
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, period_cnt=0; tx_out low immediately, even mid-burst.
// - FSM states: IDLE, CLEAR, START, BURST, CAPTURE, LATCH, WAIT.
// - IDLE: if enable=1, go to CLEAR on the next cycle.
// - CLEAR: fifo_aclr=1 for exactly FIFO_CLR_CYC cycles, then START.
// - START: one cycle. sys_start_pulse=1, period_cnt<=0, fifo_wren_en rises this cycle (sample 0 = TX start).
// - BURST: tx_out starts high and toggles every TX_HALF_CYC clocks, giving 2*TX_CYCLES half-periods; then tx_out=0 and go to CAPTURE.
// - fifo_wren_en stays high through BURST and CAPTURE.
// - proc_done: ignored in START and BURST; sampled as a level in CAPTURE, since the correlator clears it one cycle after START.
// - CAPTURE: proc_done=1 -> LATCH, registering hit_flag/echo_tof/echo_peak.
// - Timeout: period_cnt==PROC_TIMEOUT_CYC in BURST or CAPTURE -> LATCH with result_hit=0.
//   result_tof/result_peak take the current inputs; timeout_err pulses. tx_out forced 0.
// - LATCH: one cycle. result_valid=1, meas_cnt++, fifo_wren_en=0 from this cycle on, then WAIT.
// - WAIT: when period_cnt==PERIOD_CYC-FIFO_CLR_CYC-1, go to CLEAR if enable=1, else IDLE.
//   The next START therefore lands exactly PERIOD_CYC clocks after the previous one.
// - enable low mid-measurement: the measurement completes through LATCH, then the FSM returns to IDLE.
//   In CLEAR the START still follows (no partial cycles).
// - Simultaneous proc_done and timeout in the same cycle: proc_done wins and timeout_err stays 0.
// - result_* hold their value until the next LATCH.
// - period_cnt: 19-bit, saturates at PERIOD_CYC-1, and is used only as described above.
// STRUCTURE
// - Shared package echo_pkg: FSM state enum, default PERIOD/TX/timeout constants, TOF_W=20, PEAK_W=18.
// - Sub-module tx_burst_gen (inputs start, abort; outputs tx_out, burst_done; params TX_HALF_CYC, TX_CYCLES).
// - The FSM, period counter and result registers remain in this module.
// TESTING
// Sim params: PERIOD_CYC=2000, TX_HALF_CYC=4, TX_CYCLES=3, FIFO_CLR_CYC=4, PROC_TIMEOUT_CYC=1500.
// 1 Reset, enable=1 -> fifo_aclr high 4 cycles; sys_start_pulse 1 cycle; tx_out 24 cycles (6 edges, period 8); fifo_wren_en high.
// 2 proc_done at cnt 600 with hit=1,tof=0x123,peak=0x2AB -> next cycle result_valid=1 with those values, meas_cnt=1, fifo_wren_en=0.
// 3 proc_done never asserts -> at cnt 1500: result_valid=1, timeout_err=1, result_hit=0.
// 4 Continuous run -> successive sys_start_pulse exactly 2000 clocks apart over 5 cycles; proc_done held high during START/BURST is ignored.
// 5 enable drops mid-CAPTURE -> result still latched, FSM reaches IDLE, no further sys_start_pulse; re-enable restarts from CLEAR.
// 6 rst_n low mid-BURST -> tx_out, fifo_wren_en, busy are 0 asynchronously; meas_cnt=0; restart is clean.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and default constants for the echo ranging sequencer.
package echo_pkg;

  localparam int unsigned DEF_PERIOD_CYC       = 500000;
  localparam int unsigned DEF_TX_HALF_CYC      = 278;
  localparam int unsigned DEF_TX_CYCLES        = 10;
  localparam int unsigned DEF_FIFO_CLR_CYC     = 8;
  localparam int unsigned DEF_PROC_TIMEOUT_CYC = 400000;

  localparam int unsigned TOF_W  = 20;
  localparam int unsigned PEAK_W = 18;
  localparam int unsigned PCNT_W = 19;
  localparam int unsigned MEAS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_BURST,
    ST_CAPTURE,
    ST_LATCH,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/echo_meas_sequencer_tx_burst_gen.sv
// Transducer burst generator: square wave of TX_CYCLES periods, starting high.
module tx_burst_gen #(
  parameter int unsigned TX_HALF_CYC = 278,
  parameter int unsigned TX_CYCLES   = 10
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic tx_out,
  output logic burst_done
);

  localparam int unsigned HALF_W = $clog2(TX_HALF_CYC + 1);
  localparam int unsigned EDGE_W = $clog2(2 * TX_CYCLES + 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(TX_HALF_CYC - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * TX_CYCLES - 1);

  logic              active_q, active_d;
  logic              tx_q, tx_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;

  // burst_done marks the final clock of the last half-period
  assign burst_done = active_q && (half_cnt_q == HALF_LAST) && (edge_cnt_q == EDGE_LAST);
  assign tx_out     = tx_q;

  // Half-period and half-period-count sequencing; abort has priority over start
  always_comb begin
    active_d   = active_q;
    tx_d       = tx_q;
    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    if (abort) begin
      active_d   = 1'b0;
      tx_d       = 1'b0;
      half_cnt_d = '0;
      edge_cnt_d = '0;
    end else if (start) begin
      active_d   = 1'b1;
      tx_d       = 1'b1;
      half_cnt_d = '0;
      edge_cnt_d = '0;
    end else if (active_q) begin
      if (half_cnt_q == HALF_LAST) begin
        half_cnt_d = '0;
        if (edge_cnt_q == EDGE_LAST) begin
          active_d   = 1'b0;
          tx_d       = 1'b0;
          edge_cnt_d = '0;
        end else begin
          tx_d       = ~tx_q;
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
      end
    end
  end

  // Burst state registers; reset drops the drive line immediately
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      tx_q       <= 1'b0;
      half_cnt_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      active_q   <= active_d;
      tx_q       <= tx_d;
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

endmodule

// File: rtl/echo_meas_sequencer.sv
// Ranging-cycle scheduler: FIFO flush, correlator start, TX burst, capture gating,
// completion/timeout wait and result latching, repeated every PERIOD_CYC clocks.
module echo_meas_sequencer
  import echo_pkg::*;
#(
  parameter int unsigned PERIOD_CYC       = DEF_PERIOD_CYC,
  parameter int unsigned TX_HALF_CYC      = DEF_TX_HALF_CYC,
  parameter int unsigned TX_CYCLES        = DEF_TX_CYCLES,
  parameter int unsigned FIFO_CLR_CYC     = DEF_FIFO_CLR_CYC,
  parameter int unsigned PROC_TIMEOUT_CYC = DEF_PROC_TIMEOUT_CYC
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              proc_done,
  input  logic              hit_flag,
  input  logic [TOF_W-1:0]  echo_tof,
  input  logic [PEAK_W-1:0] echo_peak,
  output logic              sys_start_pulse,
  output logic              fifo_aclr,
  output logic              fifo_wren_en,
  output logic              tx_out,
  output logic              result_valid,
  output logic              result_hit,
  output logic [TOF_W-1:0]  result_tof,
  output logic [PEAK_W-1:0] result_peak,
  output logic              timeout_err,
  output logic              busy,
  output logic [MEAS_W-1:0] meas_cnt
);

  localparam int unsigned CLR_W = $clog2(FIFO_CLR_CYC + 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(FIFO_CLR_CYC - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(PERIOD_CYC - 1);
  localparam logic [PCNT_W-1:0] WAIT_LAST = PCNT_W'(PERIOD_CYC - FIFO_CLR_CYC - 1);
  localparam logic [PCNT_W-1:0] TIMEOUT   = PCNT_W'(PROC_TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [PCNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic                res_hit_q, res_hit_d;
  logic [TOF_W-1:0]    res_tof_q, res_tof_d;
  logic [PEAK_W-1:0]   res_peak_q, res_peak_d;
  logic                to_q, to_d;
  logic [MEAS_W-1:0]   meas_cnt_q, meas_cnt_d;

  logic burst_start;
  logic burst_abort;
  logic burst_done;
  logic take_done;
  logic take_timeout;
  logic timeout_hit;

  assign timeout_hit = (period_cnt_q == TIMEOUT);
  assign burst_start = (state_q == ST_START);
  assign burst_abort = take_timeout;

  tx_burst_gen #(
    .TX_HALF_CYC (TX_HALF_CYC),
    .TX_CYCLES   (TX_CYCLES)
  ) u_tx_burst_gen (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .start      (burst_start),
    .abort      (burst_abort),
    .tx_out     (tx_out),
    .burst_done (burst_done)
  );

  // Control outputs decode straight from the state so reset clears them at once
  assign fifo_aclr       = (state_q == ST_CLEAR);
  assign sys_start_pulse = (state_q == ST_START);
  assign fifo_wren_en    = (state_q == ST_START) || (state_q == ST_BURST) ||
                           (state_q == ST_CAPTURE);
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_WAIT);
  assign result_valid    = (state_q == ST_LATCH);
  assign timeout_err     = (state_q == ST_LATCH) && to_q;
  assign result_hit      = res_hit_q;
  assign result_tof      = res_tof_q;
  assign result_peak     = res_peak_q;
  assign meas_cnt        = meas_cnt_q;

  // Next-state, period counter and result capture
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = '0;
    res_hit_d    = res_hit_q;
    res_tof_d    = res_tof_q;
    res_peak_d   = res_peak_q;
    to_d         = to_q;
    meas_cnt_d   = meas_cnt_q;
    take_done    = 1'b0;
    take_timeout = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) state_d = ST_START;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_START: state_d = ST_BURST;
      ST_BURST: begin
        if (timeout_hit) take_timeout = 1'b1;
        else if (burst_done) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (proc_done) take_done = 1'b1;
        else if (timeout_hit) take_timeout = 1'b1;
      end
      ST_LATCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (period_cnt_q == WAIT_LAST) state_d = enable ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_done || take_timeout) begin
      state_d    = ST_LATCH;
      res_hit_d  = take_done ? hit_flag : 1'b0;
      res_tof_d  = echo_tof;
      res_peak_d = echo_peak;
      to_d       = take_timeout;
      meas_cnt_d = meas_cnt_q + 1'b1;
    end

    // Counter reads 0 during START so the WAIT exit lands the next START
    // exactly PERIOD_CYC clocks later
    if (state_d == ST_START) period_cnt_d = '0;
    else if (period_cnt_q != PCNT_MAX) period_cnt_d = period_cnt_q + 1'b1;
    else period_cnt_d = period_cnt_q;
  end

  // State, counters and result registers
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      period_cnt_q <= '0;
      res_hit_q    <= 1'b0;
      res_tof_q    <= '0;
      res_peak_q   <= '0;
      to_q         <= 1'b0;
      meas_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      period_cnt_q <= period_cnt_d;
      res_hit_q    <= res_hit_d;
      res_tof_q    <= res_tof_d;
      res_peak_q   <= res_peak_d;
      to_q         <= to_d;
      meas_cnt_q   <= meas_cnt_d;
    end
  end

endmodule

// File: tb/tb_echo_meas_sequencer.sv
// Directed bench for echo_meas_sequencer with shortened timing parameters.
module tb_echo_meas_sequencer;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        proc_done;
  logic        hit_flag;
  logic [19:0] echo_tof;
  logic [17:0] echo_peak;
  logic        sys_start_pulse;
  logic        fifo_aclr;
  logic        fifo_wren_en;
  logic        tx_out;
  logic        result_valid;
  logic        result_hit;
  logic [19:0] result_tof;
  logic [17:0] result_peak;
  logic        timeout_err;
  logic        busy;
  logic [15:0] meas_cnt;

  // {fifo_aclr, sys_start_pulse, fifo_wren_en, tx_out, busy, result_valid, timeout_err}
  logic [6:0]  ctl;
  logic [38:0] res;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;

  assign ctl = {fifo_aclr, sys_start_pulse, fifo_wren_en, tx_out, busy, result_valid, timeout_err};
  assign res = {result_hit, result_tof, result_peak};

  always #5 clk_50M = ~clk_50M;

  echo_meas_sequencer #(
    .PERIOD_CYC       (2000),
    .TX_HALF_CYC      (4),
    .TX_CYCLES        (3),
    .FIFO_CLR_CYC     (4),
    .PROC_TIMEOUT_CYC (1500)
  ) dut (
    .clk_50M         (clk_50M),
    .rst_n           (rst_n),
    .enable          (enable),
    .proc_done       (proc_done),
    .hit_flag        (hit_flag),
    .echo_tof        (echo_tof),
    .echo_peak       (echo_peak),
    .sys_start_pulse (sys_start_pulse),
    .fifo_aclr       (fifo_aclr),
    .fifo_wren_en    (fifo_wren_en),
    .tx_out          (tx_out),
    .result_valid    (result_valid),
    .result_hit      (result_hit),
    .result_tof      (result_tof),
    .result_peak     (result_peak),
    .timeout_err     (timeout_err),
    .busy            (busy),
    .meas_cnt        (meas_cnt)
  );

  task automatic tick();
    @(posedge clk_50M);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for the next start strobe and checks its distance from the last one
  task automatic wait_start(input int exp_gap);
    int n = 0;
    while (sys_start_pulse !== 1'b1 && n < 2100) begin
      tick();
      n++;
    end
    n_vec++;
    if (sys_start_pulse !== 1'b1 || cyc != exp_gap) begin
      n_err++;
      $display("FAIL start_gap: got start=%b gap=%0d, expected start=1 gap=%0d",
               sys_start_pulse, cyc, exp_gap);
    end
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    proc_done = 1'b0;
    hit_flag  = 1'b0;
    echo_tof  = '0;
    echo_peak = '0;
    #23;
    n_vec++;
    if (ctl !== 7'b0000000 || meas_cnt !== 16'd0 || res !== 39'd0) begin
      n_err++;
      $display("FAIL reset_state: got ctl=%b meas=%0d res=%h, expected 0000000 0 0", ctl, meas_cnt, res);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (ctl !== 7'b0000000) begin
      n_err++;
      $display("FAIL idle_disabled: got ctl=%b expected 0000000", ctl);
    end
  endtask

  task automatic test_first_burst();
    enable = 1'b1;
    cyc    = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (ctl !== 7'b1000100) begin
        n_err++;
        $display("FAIL clear_cycle%0d: got ctl=%b expected 1000100", i, ctl);
      end
    end
    tick();
    n_vec++;
    if (ctl !== 7'b0110100) begin
      n_err++;
      $display("FAIL start_cycle: got ctl=%b expected 0110100", ctl);
    end
    cyc = 0;
    for (int k = 1; k <= 24; k++) begin
      logic [6:0] exp_ctl;
      tick();
      exp_ctl = {3'b001, (((k - 1) / 4) % 2 == 0), 3'b100};
      n_vec++;
      if (ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL burst_k%0d: got ctl=%b expected %b", k, ctl, exp_ctl);
      end
    end
    for (int k = 25; k <= 28; k++) begin
      tick();
      n_vec++;
      if (ctl !== 7'b0010100) begin
        n_err++;
        $display("FAIL capture_k%0d: got ctl=%b expected 0010100", k, ctl);
      end
    end
  endtask

  task automatic test_proc_done();
    while (cyc < 600) tick();
    proc_done = 1'b1;
    hit_flag  = 1'b1;
    echo_tof  = 20'h00123;
    echo_peak = 18'h002AB;
    tick();
    n_vec++;
    if (ctl !== 7'b0000110 || res !== {1'b1, 20'h00123, 18'h002AB} || meas_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL done_latch: got ctl=%b res=%h meas=%0d, expected 0000110 %h 1",
               ctl, res, meas_cnt, {1'b1, 20'h00123, 18'h002AB});
    end
    proc_done = 1'b0;
    echo_tof  = 20'h00000;
    tick();
    n_vec++;
    if (ctl !== 7'b0000000 || res !== {1'b1, 20'h00123, 18'h002AB}) begin
      n_err++;
      $display("FAIL done_hold: got ctl=%b res=%h, expected 0000000 %h",
               ctl, res, {1'b1, 20'h00123, 18'h002AB});
    end
  endtask

  task automatic test_timeout();
    hit_flag  = 1'b1;
    echo_tof  = 20'hABCDE;
    echo_peak = 18'h3FFFF;
    wait_start(2000);
    while (cyc < 1500) tick();
    n_vec++;
    if (ctl !== 7'b0010100) begin
      n_err++;
      $display("FAIL pre_timeout: got ctl=%b expected 0010100", ctl);
    end
    tick();
    n_vec++;
    if (ctl !== 7'b0000111 || res !== {1'b0, 20'hABCDE, 18'h3FFFF} || meas_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL timeout_latch: got ctl=%b res=%h meas=%0d, expected 0000111 %h 2",
               ctl, res, meas_cnt, {1'b0, 20'hABCDE, 18'h3FFFF});
    end
    tick();
    n_vec++;
    if (ctl !== 7'b0000000) begin
      n_err++;
      $display("FAIL timeout_after: got ctl=%b expected 0000000", ctl);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      logic [38:0] exp_res;
      wait_start(2000);
      proc_done = 1'b1;
      hit_flag  = i[0];
      echo_tof  = 20'(32'h01000 + i);
      echo_peak = 18'(32'h00100 * i);
      exp_res   = {i[0], 20'(32'h01000 + i), 18'(32'h00100 * i)};
      while (cyc < 24) tick();
      proc_done = 1'b0;
      tick();
      n_vec++;
      if (ctl !== 7'b0010100 || meas_cnt !== 16'(2 + i)) begin
        n_err++;
        $display("FAIL early_done_ignored%0d: got ctl=%b meas=%0d, expected 0010100 %0d",
                 i, ctl, meas_cnt, 2 + i);
      end
      while (cyc < 100) tick();
      proc_done = 1'b1;
      tick();
      n_vec++;
      if (ctl !== 7'b0000110 || res !== exp_res || meas_cnt !== 16'(3 + i)) begin
        n_err++;
        $display("FAIL b2b_latch%0d: got ctl=%b res=%h meas=%0d, expected 0000110 %h %0d",
                 i, ctl, res, meas_cnt, exp_res, 3 + i);
      end
      proc_done = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    int starts = 0;
    wait_start(2000);
    while (cyc < 200) tick();
    enable = 1'b0;
    while (cyc < 300) tick();
    proc_done = 1'b1;
    hit_flag  = 1'b1;
    echo_tof  = 20'h55555;
    echo_peak = 18'h0AAAA;
    tick();
    n_vec++;
    if (ctl !== 7'b0000110 || res !== {1'b1, 20'h55555, 18'h0AAAA} || meas_cnt !== 16'd8) begin
      n_err++;
      $display("FAIL drop_latch: got ctl=%b res=%h meas=%0d, expected 0000110 %h 8",
               ctl, res, meas_cnt, {1'b1, 20'h55555, 18'h0AAAA});
    end
    proc_done = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      tick();
      if (sys_start_pulse || fifo_aclr) starts++;
    end
    n_vec++;
    if (starts != 0 || ctl !== 7'b0000000) begin
      n_err++;
      $display("FAIL drop_idle: got restarts=%0d ctl=%b, expected 0 0000000", starts, ctl);
    end
    enable = 1'b1;
    cyc    = 0;
    tick();
    n_vec++;
    if (ctl !== 7'b1000100) begin
      n_err++;
      $display("FAIL reenable_clear: got ctl=%b expected 1000100", ctl);
    end
    wait_start(5);
  endtask

  task automatic test_reset_mid_burst();
    while (cyc < 10) tick();
    n_vec++;
    if (ctl !== 7'b0011100) begin
      n_err++;
      $display("FAIL mid_burst: got ctl=%b expected 0011100", ctl);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ctl !== 7'b0000000 || meas_cnt !== 16'd0 || res !== 39'd0) begin
      n_err++;
      $display("FAIL async_reset: got ctl=%b meas=%0d res=%h, expected 0000000 0 0", ctl, meas_cnt, res);
    end
    #20;
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    n_vec++;
    if (ctl !== 7'b1000100) begin
      n_err++;
      $display("FAIL restart_clear: got ctl=%b expected 1000100", ctl);
    end
    wait_start(5);
    while (cyc < 50) tick();
    proc_done = 1'b1;
    hit_flag  = 1'b0;
    echo_tof  = 20'h00001;
    echo_peak = 18'h00002;
    tick();
    n_vec++;
    if (ctl !== 7'b0000110 || res !== {1'b0, 20'h00001, 18'h00002} || meas_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL restart_latch: got ctl=%b res=%h meas=%0d, expected 0000110 %h 1",
               ctl, res, meas_cnt, {1'b0, 20'h00001, 18'h00002});
    end
    proc_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_burst();
    test_proc_done();
    test_timeout();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
